// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Formats load data before capture so write_data comes straight from a flop.
// Drives the register file write port and keeps the retired-instruction count.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  output logic [4:0]      write_address,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable,
  output logic            wb_valid,
  output logic            load_fault,
  output logic [63:0]     instret
);

  logic            valid_q, valid_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;
  logic [63:0]     instret_q, instret_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            ld_fault;
  logic [XLEN-1:0] cap_data;
  logic            cap_fault;

  // Load formatting: pick the addressed byte/halfword, extend, and flag misalignment.
  always_comb begin
    ld_data  = '0;
    ld_fault = 1'b0;
    case (in_addr_lo)
      2'd0:    ld_byte = in_load_data[7:0];
      2'd1:    ld_byte = in_load_data[15:8];
      2'd2:    ld_byte = in_load_data[23:16];
      default: ld_byte = in_load_data[31:24];
    endcase
    ld_half = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
    case (in_funct3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'd0, ld_byte};
      3'b001: begin
        ld_fault = in_addr_lo[0];
        ld_data  = {{16{ld_half[15]}}, ld_half};
      end
      3'b101: begin
        ld_fault = in_addr_lo[0];
        ld_data  = {16'd0, ld_half};
      end
      3'b010: begin
        ld_fault = (in_addr_lo != 2'd0);
        ld_data  = in_load_data;
      end
      default: ld_fault = 1'b1;
    endcase
    if (ld_fault) begin
      ld_data = '0;
    end
  end

  // Result source select; reserved encoding 11 falls back to the ALU result.
  always_comb begin
    cap_fault = in_valid & (in_wb_sel == 2'b01) & ld_fault;
    case (in_wb_sel)
      2'b01:   cap_data = ld_data;
      2'b10:   cap_data = in_pc_plus4;
      default: cap_data = in_alu_result;
    endcase
  end

  // Next-state: rst > flush > stall > capture; instret counts each WB occupant once.
  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    data_d      = data_q;
    fault_d     = fault_q;
    instret_d   = instret_q;
    if (rst) begin
      valid_d     = 1'b0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      data_d      = '0;
      fault_d     = 1'b0;
      instret_d   = '0;
    end else begin
      if (valid_q && !stall_i) begin
        instret_d = instret_q + 64'd1;
      end
      if (flush_i) begin
        valid_d     = 1'b0;
        rd_d        = '0;
        reg_write_d = 1'b0;
        data_d      = '0;
        fault_d     = 1'b0;
      end else if (!stall_i) begin
        valid_d     = in_valid;
        rd_d        = in_rd;
        reg_write_d = in_reg_write;
        data_d      = cap_data;
        fault_d     = cap_fault;
      end
    end
  end

  // Pipeline register update.
  always_ff @(posedge clk) begin
    valid_q     <= valid_d;
    rd_q        <= rd_d;
    reg_write_q <= reg_write_d;
    data_q      <= data_d;
    fault_q     <= fault_d;
    instret_q   <= instret_d;
  end

  assign write_address = rd_q;
  assign write_data    = data_q;
  assign wb_valid      = valid_q;
  assign load_fault    = fault_q;
  assign instret       = instret_q;
  assign write_enable  = valid_q & reg_write_q & (rd_q != 5'd0) & ~fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a behavioural reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_addr_lo;
  logic [31:0] in_alu_result, in_pc_plus4, in_load_data;
  logic [2:0]  in_funct3;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        write_enable, wb_valid, load_fault;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  // model of what WB holds
  logic        m_valid, m_rw, m_fault;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_instret;
  logic [63:0] saved_instret;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_load_data(in_load_data),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .wb_valid(wb_valid),
    .load_fault(load_fault), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected load result computed arithmetically from the load rules.
  function automatic logic [32:0] load_result(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [31:0] b, h;
    int unsigned boff, hoff;
    boff = 8 * int'(off);
    hoff = (int'(off) >= 2) ? 16 : 0;
    b = (word >> boff) & 32'hFF;
    h = (word >> hoff) & 32'hFFFF;
    if (f3 == 3'd0) return {1'b0, (b >= 32'd128) ? b + 32'hFFFFFF00 : b};
    if (f3 == 3'd4) return {1'b0, b};
    if (f3 == 3'd1 || f3 == 3'd5) begin
      if (int'(off) % 2 != 0) return {1'b1, 32'd0};
      if (f3 == 3'd1 && h >= 32'h8000) return {1'b0, h + 32'hFFFF0000};
      return {1'b0, h};
    end
    if (f3 == 3'd2) return (off == 2'd0) ? {1'b0, word} : {1'b1, 32'd0};
    return {1'b1, 32'd0};
  endfunction

  task automatic model_step();
    logic [32:0] lr;
    if (rst) begin
      m_valid = 0; m_rw = 0; m_fault = 0; m_rd = 0; m_data = 0; m_instret = 0;
    end else begin
      if (m_valid && !stall_i) m_instret = m_instret + 1;
      if (flush_i) begin
        m_valid = 0; m_rw = 0; m_fault = 0; m_rd = 0; m_data = 0;
      end else if (!stall_i) begin
        lr      = load_result(in_load_data, in_funct3, in_addr_lo);
        m_valid = in_valid;
        m_rd    = in_rd;
        m_rw    = in_reg_write;
        m_fault = in_valid && in_wb_sel == 2'b01 && lr[32];
        m_data  = (in_wb_sel == 2'b01) ? lr[31:0] : (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
      end
    end
  endtask

  task automatic compare_model();
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
    chk("write_enable", {63'd0, write_enable},
        {63'd0, m_valid && m_rw && m_rd != 0 && !m_fault});
    chk("load_fault", {63'd0, load_fault}, {63'd0, m_fault});
    chk("instret", instret, m_instret);
    if (m_valid) begin
      chk("write_address", {59'd0, write_address}, {59'd0, m_rd});
      chk("write_data", {32'd0, write_data}, {32'd0, m_data});
    end
  endtask

  // One clock: model follows the posedge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] ld,
                       input logic [2:0] f3, input logic [1:0] lo);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
    in_alu_result = alu; in_pc_plus4 = pc4; in_load_data = ld;
    in_funct3 = f3; in_addr_lo = lo;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp);
    issue(1, 5'd10, 1, 2'b01, {30'd0, lo}, 32'd0, 32'h80FF_7F01, f3, lo);
    tick();
    chk("load_data_lit", {32'd0, write_data}, {32'd0, exp});
    chk("load_we_lit", {63'd0, write_enable}, 64'd1);
  endtask

  task automatic fault(input logic [2:0] f3, input logic [1:0] lo);
    issue(1, 5'd11, 1, 2'b01, {30'd0, lo}, 32'd0, 32'h80FF_7F01, f3, lo);
    tick();
    chk("fault_flag_lit", {63'd0, load_fault}, 64'd1);
    chk("fault_we_lit", {63'd0, write_enable}, 64'd0);
    chk("fault_data_lit", {32'd0, write_data}, 64'd0);
  endtask

  initial begin
    rst = 1; stall_i = 0; flush_i = 0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    chk("rst_addr_lit", {59'd0, write_address}, 64'd0);
    chk("rst_data_lit", {32'd0, write_data}, 64'd0);
    chk("rst_we_lit", {63'd0, write_enable}, 64'd0);
    chk("rst_valid_lit", {63'd0, wb_valid}, 64'd0);
    chk("rst_fault_lit", {63'd0, load_fault}, 64'd0);
    chk("rst_instret_lit", instret, 64'd0);
    rst = 0;

    issue(1, 5'd5, 1, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    chk("alu_addr_lit", {59'd0, write_address}, 64'd5);
    chk("alu_data_lit", {32'd0, write_data}, 64'h1234_5678);
    chk("alu_we_lit", {63'd0, write_enable}, 64'd1);
    issue(0, 5'd4, 1, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    chk("alu_instret_lit", instret, 64'd1);
    chk("bubble_valid_lit", {63'd0, wb_valid}, 64'd0);
    chk("bubble_we_lit", {63'd0, write_enable}, 64'd0);

    load(3'b000, 2'd3, 32'hFFFF_FF80);
    load(3'b100, 2'd1, 32'h0000_007F);
    load(3'b001, 2'd2, 32'hFFFF_80FF);
    load(3'b101, 2'd0, 32'h0000_7F01);
    load(3'b010, 2'd0, 32'h80FF_7F01);

    fault(3'b010, 2'd2);
    fault(3'b001, 2'd1);
    fault(3'b011, 2'd0);

    // rd = 0 never written, then JAL link value
    issue(1, 5'd0, 1, 2'b00, 32'h55, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    chk("x0_we_lit", {63'd0, write_enable}, 64'd0);
    chk("x0_valid_lit", {63'd0, wb_valid}, 64'd1);
    issue(1, 5'd1, 1, 2'b10, 32'h99, 32'h104, 32'd0, 3'd0, 2'd0);
    tick();
    chk("jal_data_lit", {32'd0, write_data}, 64'h104);
    issue(1, 5'd2, 1, 2'b11, 32'h77, 32'h104, 32'd0, 3'd0, 2'd0);
    tick();
    chk("sel11_data_lit", {32'd0, write_data}, 64'h77);

    // stall for three cycles while inputs change
    issue(1, 5'd7, 1, 2'b00, 32'hCAFE, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    saved_instret = instret;
    stall_i = 1;
    issue(1, 5'd8, 1, 2'b10, 32'h1, 32'h2, 32'd0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr_lit", {59'd0, write_address}, 64'd7);
      chk("stall_data_lit", {32'd0, write_data}, 64'hCAFE);
      chk("stall_we_lit", {63'd0, write_enable}, 64'd1);
      chk("stall_instret", instret, saved_instret);
    end
    flush_i = 1;
    tick();
    chk("flush_stall_valid_lit", {63'd0, wb_valid}, 64'd0);
    chk("flush_stall_we_lit", {63'd0, write_enable}, 64'd0);
    stall_i = 0; flush_i = 0;

    issue(1, 5'd12, 1, 2'b00, 32'h42, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    flush_i = 1;
    tick();
    chk("flush_valid_lit", {63'd0, wb_valid}, 64'd0);
    flush_i = 0;

    // instret wrap
    issue(1, 5'd3, 1, 2'b00, 32'h33, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    #2;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    chk("preload_instret_lit", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(0, 5'd0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    chk("wrap_instret_lit", instret, 64'd0);

    // reset mid-stream drops the in-flight instruction
    issue(1, 5'd9, 1, 2'b00, 32'h9999, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    issue(1, 5'd13, 1, 2'b01, 32'd1, 32'd0, 32'h80FF_7F01, 3'b001, 2'd1);
    rst = 1;
    tick();
    chk("midrst_addr_lit", {59'd0, write_address}, 64'd0);
    chk("midrst_data_lit", {32'd0, write_data}, 64'd0);
    chk("midrst_we_lit", {63'd0, write_enable}, 64'd0);
    chk("midrst_valid_lit", {63'd0, wb_valid}, 64'd0);
    chk("midrst_fault_lit", {63'd0, load_fault}, 64'd0);
    chk("midrst_instret_lit", instret, 64'd0);
    rst = 0;
    issue(1, 5'd6, 1, 2'b00, 32'h6, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the 32-bit pipelined core. It captures the result of each instruction leaving the memory stage and formats load data: byte/halfword selection plus sign or zero extension. It then drives the register file write port and the writeback forwarding path, and keeps the 64-bit retired-instruction counter. It sits directly upstream of the register file, which samples this block's write port on the falling edge of the same cycle.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold the current WB contents.
- flush_i  in  1  replace the incoming instruction with a bubble.
- in_valid  in  1  MEM stage holds a real instruction.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes rd.
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- in_alu_result  in  32  ALU result.
- in_pc_plus4  in  32  link value.
- in_load_data  in  32  raw aligned word from data memory.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  byte offset of the load address, i.e. in_alu_result[1:0].
- write_address  out  5  register file write address.
- write_data  out  32  register file write data; also the forwarding value.
- write_enable  out  1  register file write strobe.
- wb_valid  out  1  WB holds a real instruction.
- load_fault  out  1  WB holds a misaligned or illegal load.
- instret  out  64  retired-instruction count.

## Operation
- Posedge priority order: rst, then flush_i, then stall_i, then normal capture.
- rst: all state cleared to zero; wb_valid = 0; instret = 0.
- flush_i: wb_valid <= 0. Other fields are don't-care but are driven to 0.
- stall_i (without flush_i): every register holds its value, including instret.
- Normal capture: fields are latched from the in_* ports. Data is formatted before capture, so write_data is a direct register output.
- Formatting for wb_sel = 01, by in_funct3:
  - 000 LB: byte at offset in_addr_lo, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at in_addr_lo[1] (0 selects [15:0], 1 selects [31:16]), sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: the full word.
- Faults, captured into load_fault with captured data = 0:
  - LH/LHU with in_addr_lo[0] = 1.
  - LW with in_addr_lo != 0.
  - funct3 of 011, 110 or 111.
- Non-load sources: wb_sel 10 selects in_pc_plus4; wb_sel 00 and 11 select in_alu_result.
- load_fault is only captured when in_valid = 1 and wb_sel = 01; otherwise it is 0.
- write_enable = wb_valid & reg_write_q & (rd_q != 0) & !load_fault. x0 is never written.
- instret increments by 1 on a posedge where wb_valid = 1, stall_i = 0 and rst = 0. Faulting loads are counted as retired. The count wraps modulo 2^64.

## Timing
- Latency is 1 cycle: an instruction presented at posedge N appears on the outputs after posedge N, and the register file writes it on the falling edge of cycle N.
- All outputs are registered or simple AND terms of registered bits. There is no combinational path from in_* to any output.
- Output reset values: write_address 0, write_data 0, write_enable 0, wb_valid 0, load_fault 0, instret 0.
- While stalled, write_enable stays asserted and rewrites the same value each cycle (idempotent). instret does not advance while stalled.
- flush_i and stall_i asserted together: the flush wins and WB becomes a bubble.
- rst asserted mid-stream: the in-flight instruction is dropped without a write, and instret clears on the same edge.
- An in_valid = 0 capture yields wb_valid = 0, and therefore write_enable = 0, regardless of the other inputs.

## Test plan
- Reset, then ALU op rd = 5, alu = 0x1234_5678 -> next cycle write_address 5, write_data 0x12345678, write_enable 1, instret 1.
- Load word 0x80FF_7F01:
  - LB at offset 3 -> 0xFFFFFF80.
  - LBU at offset 1 -> 0x0000007F.
  - LH at offset 2 -> 0xFFFF80FF.
  - LHU at offset 0 -> 0x00007F01.
- Faults: LW at offset 2, LH at offset 1, and funct3 = 011 -> load_fault 1, write_enable 0, write_data 0, instret still increments.
- rd = 0 with reg_write = 1 -> write_enable 0, wb_valid 1. JAL rd = 1, pc_plus4 = 0x104 -> write_data 0x104.
- Hold stall_i for 3 cycles -> outputs held and instret unchanged. Assert flush_i with stall_i -> wb_valid 0 next cycle.
- Preload instret to 0xFFFF_FFFF_FFFF_FFFF (force) and retire one instruction -> instret 0. Assert rst mid-stream -> all outputs 0 on the next cycle.
